db_serial_ctrl: RTL and testbench

DB_SERIAL_CTRL -- requirements
Module: db_serial_ctrl

---
 rtl/db_serial_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_db_serial_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/db_serial_ctrl.sv
// UART command front-end for a debugger wrapper: decodes opcode/address/data frames,
// issues one-cycle command strobes, then replies with read data or an ack byte.
module db_serial_ctrl #(
  parameter int CLK_RATE = 50,
  parameter int BAUD     = 115200,
  parameter int TO_BITS  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        srx,
  output logic        stx,
  input  logic        mcu_busy,
  input  logic [31:0] d_rd,
  output logic        valid,
  output logic        pause,
  output logic        resume,
  output logic        reset,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [31:0] addr,
  output logic [31:0] d_in
);
  localparam int DIV = (CLK_RATE * 1000000) / BAUD;
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, WAIT, REPLY} state_t;
  state_t state, state_nx;

  logic s1, s2, s3;
  logic rx_busy, rx_valid;
  logic [15:0] rx_cnt;
  logic [3:0] rx_bit;
  logic [7:0] rx_sh;
  logic tx_busy, tx_start, tx_last;
  logic [15:0] tx_cnt;
  logic [3:0] tx_bit;
  logic [8:0] tx_sh;
  logic [7:0] tx_data;
  logic [7:0] op;
  logic [1:0] bcnt;
  logic [TO_BITS-1:0] tmo;
  logic [2:0] rem;
  logic [31:0] rep_sh;
  logic timeout, is_wr, is_rd;

  assign timeout = &tmo;
  assign is_wr   = (op == 8'h04) || (op == 8'h06);
  assign is_rd   = (op == 8'h03) || (op == 8'h05);
  assign tx_data = rep_sh[31:24];
  assign tx_last = tx_busy && (tx_cnt == DIV_M1) && (tx_bit == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, s3} <= 3'b111;
    end else begin
      s1 <= srx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // rx_bit: 0 = start check at half bit, 1..8 = data, 9 = stop
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_busy  <= 1'b0;
      rx_valid <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (s3 && !s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == HALF_M1) begin
          rx_cnt <= '0;
          if (!s2) rx_bit <= 4'd1;
          else     rx_busy <= 1'b0;
        end else begin
          rx_cnt <= rx_cnt + 16'd1;
        end
      end else if (rx_cnt == DIV_M1) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_valid <= s2;
        end else begin
          rx_sh  <= {s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 16'd1;
      end
    end
  end

  // A start on the final stop-bit clock reloads the shifter, giving back-to-back bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0;
      stx     <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      stx     <= 1'b0;
      tx_sh   <= {1'b1, tx_data};
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == DIV_M1) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          stx    <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (rx_valid) begin
        case (rx_sh)
          8'h01, 8'h02, 8'h07:        state_nx = ISSUE;
          8'h03, 8'h04, 8'h05, 8'h06: state_nx = ADDR;
          default:                    state_nx = REPLY;
        endcase
      end
      ADDR: if (timeout) state_nx = IDLE;
            else if (rx_valid && bcnt == 2'd3) state_nx = is_wr ? DATA : ISSUE;
      DATA: if (timeout) state_nx = IDLE;
            else if (rx_valid && bcnt == 2'd3) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (!mcu_busy) state_nx = REPLY;
      REPLY: if (rem == 3'd0 && tx_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    valid    = 1'b0;
    pause    = 1'b0;
    resume   = 1'b0;
    reset    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    reg_rd   = 1'b0;
    reg_wr   = 1'b0;
    tx_start = 1'b0;
    if (state == ISSUE) begin
      valid = 1'b1;
      case (op)
        8'h01:   pause  = 1'b1;
        8'h02:   resume = 1'b1;
        8'h03:   mem_rd = 1'b1;
        8'h04:   mem_wr = 1'b1;
        8'h05:   reg_rd = 1'b1;
        8'h06:   reg_wr = 1'b1;
        8'h07:   reset  = 1'b1;
        default: ;
      endcase
    end
    if (state == REPLY && rem != 3'd0 && (!tx_busy || tx_last)) tx_start = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= '0;
      bcnt   <= '0;
      tmo    <= '0;
      rem    <= '0;
      rep_sh <= '0;
      addr   <= '0;
      d_in   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo <= '0;
          if (rx_valid) begin
            op   <= rx_sh;
            bcnt <= '0;
            if (rx_sh == 8'h00 || rx_sh > 8'h07) begin
              rep_sh <= {8'hEE, 24'h0};
              rem    <= 3'd1;
            end
          end
        end
        ADDR, DATA: begin
          if (rx_valid) begin
            if (state == ADDR) addr <= {addr[23:0], rx_sh};
            else               d_in <= {d_in[23:0], rx_sh};
            bcnt <= bcnt + 2'd1;
            tmo  <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WAIT: if (!mcu_busy) begin
          rep_sh <= is_rd ? d_rd : {8'hA5, 24'h0};
          rem    <= is_rd ? 3'd4 : 3'd1;
        end
        REPLY: if (tx_start) begin
          rep_sh <= {rep_sh[23:0], 8'h00};
          rem    <= rem - 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_db_serial_ctrl.sv
// Bench for db_serial_ctrl: drives UART frames on srx, decodes stx, and scoreboards
// both the issued commands and the reply bytes against expected queues.
module tb_db_serial_ctrl;
  localparam int CLK_RATE = 1;
  localparam int BAUD     = 62500;
  localparam int TO_BITS  = 12;
  localparam int DIV      = (CLK_RATE * 1000000) / BAUD;

  logic clk = 1'b0;
  logic rst, srx, stx, mcu_busy;
  logic [31:0] d_rd;
  logic valid, pause, resume, reset_sel, mem_rd, mem_wr, reg_rd, reg_wr;
  logic [31:0] addr, d_in;
  logic [6:0] sels;

  db_serial_ctrl #(.CLK_RATE(CLK_RATE), .BAUD(BAUD), .TO_BITS(TO_BITS)) dut (
    .clk(clk), .rst(rst), .srx(srx), .stx(stx), .mcu_busy(mcu_busy), .d_rd(d_rd),
    .valid(valid), .pause(pause), .resume(resume), .reset(reset_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .addr(addr), .d_in(d_in)
  );

  always #5 clk = ~clk;
  assign sels = {pause, resume, reset_sel, mem_rd, mem_wr, reg_rd, reg_wr};

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [70:0] iss_q[$];
  int          busy_hold = 0;
  logic [31:0] resp_data = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_din  = '0;
  logic        prev_valid = 1'b0;
  logic [7:0]  mon_b;
  logic        mon_abort;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] sel_of(input logic [7:0] op);
    case (op)
      8'h01:   return 7'b1000000;
      8'h02:   return 7'b0100000;
      8'h07:   return 7'b0010000;
      8'h03:   return 7'b0001000;
      8'h04:   return 7'b0000100;
      8'h05:   return 7'b0000010;
      8'h06:   return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic uart_send(input logic [7:0] b, input logic stop_v);
    srx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      srx = b[i];
      repeat (DIV) @(negedge clk);
    end
    srx = stop_v;
    repeat (DIV) @(negedge clk);
    srx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) uart_send(w[i*8 +: 8], 1'b1);
  endtask

  task automatic push_reply(input logic [31:0] w, input int n);
    for (int i = 3; i > 3 - n; i--) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 72'(exp_q.size() + iss_q.size()), 72'd0);
    repeat (4 * DIV) @(negedge clk);
  endtask

  // Command strobe monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        check("valid_pulse", 72'(prev_valid), 72'd0);
        if (iss_q.size() == 0) check("valid_extra", 72'(iss_q.size()), 72'd1);
        else check("issue", {1'b0, sels, addr, d_in}, {1'b0, iss_q.pop_front()});
      end else if (sels != 7'd0) begin
        check("sel_idle", 72'(sels), 72'd0);
      end
    end
    prev_valid = valid;
  end

  // Wrapper responder: hold busy for busy_hold cycles after a strobe
  always begin
    @(negedge clk);
    if (valid && !rst) begin
      d_rd = resp_data;
      if (busy_hold > 0) begin
        mcu_busy = 1'b1;
        repeat (busy_hold) @(negedge clk);
        mcu_busy = 1'b0;
      end
    end
  end

  // stx decoder; a byte interrupted by reset is abandoned
  always begin
    @(negedge clk);
    if (!rst && stx === 1'b0) begin
      mon_abort = 1'b0;
      repeat (DIV / 2) begin @(negedge clk); if (rst) mon_abort = 1'b1; end
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) begin @(negedge clk); if (rst) mon_abort = 1'b1; end
        mon_b[i] = stx;
      end
      repeat (DIV) begin @(negedge clk); if (rst) mon_abort = 1'b1; end
      if (!mon_abort) begin
        check("stop_bit", 72'(stx), 72'd1);
        if (exp_q.size() == 0) check("tx_extra", 72'(exp_q.size()), 72'd1);
        else check("tx_byte", 72'(mon_b), 72'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] op;
    int k;
    rst = 1'b1; srx = 1'b1; mcu_busy = 1'b0; d_rd = '0;
    repeat (3) @(negedge clk);
    check("rst_stx", 72'(stx), 72'd1);
    check("rst_outs", {valid, sels, addr, d_in}, 72'd0);
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);

    // pause: strobe then ack
    iss_q.push_back({sel_of(8'h01), m_addr, m_din});
    exp_q.push_back(8'hA5);
    uart_send(8'h01, 1'b1);
    drain("drain_pause");

    // memory write
    m_addr = 32'h0000_0010; m_din = 32'hDEAD_BEEF;
    iss_q.push_back({sel_of(8'h04), m_addr, m_din});
    exp_q.push_back(8'hA5);
    uart_send(8'h04, 1'b1); send_word(m_addr); send_word(m_din);
    drain("drain_mem_wr");

    // memory read with busy stretch and a framing-error byte mid-address
    busy_hold = 3; resp_data = 32'h1234_5678; m_addr = 32'h0000_0020;
    iss_q.push_back({sel_of(8'h03), m_addr, m_din});
    push_reply(resp_data, 4);
    uart_send(8'h03, 1'b1); uart_send(8'h00, 1'b1); uart_send(8'h99, 1'b0);
    uart_send(8'h00, 1'b1); uart_send(8'h00, 1'b1); uart_send(8'h20, 1'b1);
    drain("drain_mem_rd");
    busy_hold = 0;

    // invalid opcode
    exp_q.push_back(8'hEE);
    uart_send(8'h55, 1'b1);
    drain("drain_bad_op");

    // randomized write/read frames
    for (int n = 0; n < 4; n++) begin
      op = 8'(4 + $urandom_range(0, 2));
      m_addr = $urandom;
      if (op != 8'h05) m_din = $urandom;
      resp_data = $urandom;
      iss_q.push_back({sel_of(op), m_addr, m_din});
      if (op == 8'h05) push_reply(resp_data, 4);
      else exp_q.push_back(8'hA5);
      uart_send(op, 1'b1); send_word(m_addr);
      if (op != 8'h05) send_word(m_din);
      drain("drain_rand");
    end

    // reset during the second reply byte of a read
    resp_data = 32'hCAFE_F00D; m_addr = 32'h0000_0040;
    iss_q.push_back({sel_of(8'h03), m_addr, m_din});
    exp_q.push_back(8'hCA);
    uart_send(8'h03, 1'b1); send_word(m_addr);
    k = 0;
    while (exp_q.size() != 0 && k < 20000) begin @(negedge clk); k++; end
    check("mid_first_byte", 72'(exp_q.size()), 72'd0);
    repeat (3 * DIV) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_stx", 72'(stx), 72'd1);
    check("mid_rst_outs", {valid, sels, addr, d_in}, 72'd0);
    rst = 1'b0;
    m_addr = '0; m_din = '0;
    repeat (40 * DIV) @(negedge clk);
    check("mid_rst_quiet", 72'(exp_q.size() + iss_q.size()), 72'd0);

    // partial frame times out, then a resume goes through
    uart_send(8'h05, 1'b1); uart_send(8'h00, 1'b1); uart_send(8'h00, 1'b1);
    repeat ((1 << TO_BITS) + 50 * DIV) @(negedge clk);
    iss_q.push_back({sel_of(8'h02), m_addr, m_din});
    exp_q.push_back(8'hA5);
    uart_send(8'h02, 1'b1);
    drain("drain_timeout");

    repeat (20 * DIV) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
